// File: rtl/adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl
//
// Purpose:
//    Sequential WIDTH-bit adder controller. It reuses one external 4-bit
//    carry-lookahead adder. It feeds one nibble of each operand per cycle,
//    starting with the least significant nibble, and chains the carry between
//    cycles. A WIDTH-bit addition takes WIDTH/4 RUN cycles plus one DONE cycle.
//
// Parameters:
//    WIDTH       operand width in bits; must be a multiple of 4 and >= 8
//
// Ports:
//    clk         single clock, rising-edge active
//    rst_n       asynchronous active-low reset
//    start       request a new addition (sampled in IDLE and DONE only)
//    a, b, cin   operands and carry-in, latched on an accepted start
//    slice_a     current nibble of A driven to the external adder
//    slice_b     current nibble of B driven to the external adder
//    slice_cin   running carry driven to the external adder
//    slice_s     4-bit sum returned by the external adder
//    slice_cout  carry-out returned by the external adder
//    busy        high exactly while in RUN
//    done        one-cycle pulse; s/cout (and ovf) are valid here
//    s           registered sum, filled nibble-by-nibble
//    cout        registered final carry-out
//    ovf         signed overflow flag (only with ADDER_SEQ_OVF_EN)
//
// Configuration:
//    `define ADDER_SEQ_OVF_EN adds the ovf output and its detection logic.
// ---------------------------------------------------------------------------
module adder_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [3:0]       slice_a,
   output logic [3:0]       slice_b,
   output logic             slice_cin,
   input  logic [3:0]       slice_s,
   input  logic             slice_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef ADDER_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry_r;

   // busy and done decode the state register directly. They have no
   // combinational path from any input, and reset forces them low at once.
   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Nibble mux toward the external adder. The external adder is
   // combinational, so slice_s and slice_cout settle within the same cycle
   // and are captured on the next edge. Outside RUN the bus is held at zero.
   always_comb begin
      slice_a   = 4'd0;
      slice_b   = 4'd0;
      slice_cin = 1'b0;
      if (state == RUN) begin
         slice_a   = a_r[{idx, 2'b00} +: 4];
         slice_b   = b_r[{idx, 2'b00} +: 4];
         slice_cin = carry_r;
      end
   end

   // Main FSM and datapath.
   // IDLE waits for start and latches the operands.
   // RUN processes one nibble per edge. The last nibble also captures the
   //    final carry (and overflow) and moves to DONE.
   // DONE lasts one cycle. If start is high there, the next operation is
   //    latched straight away, so no IDLE cycle is inserted between them.
   // s is not cleared on a new start. Each nibble is overwritten as RUN
   // reaches it, so s is only meaningful at done or afterwards in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
         s       <= '0;
         cout    <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  carry_r <= cin;
                  idx     <= '0;
                  state   <= RUN;
               end
            end

            RUN: begin
               s[{idx, 2'b00} +: 4] <= slice_s;
               carry_r              <= slice_cout;
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  cout  <= slice_cout;
`ifdef ADDER_SEQ_OVF_EN
                  // Signed overflow: the operand signs match, but the sign
                  // of the result differs from them. slice_s[3] is the MSB
                  // of the full sum on this last nibble.
                  ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                           (slice_s[3] != a_r[WIDTH-1]);
`endif
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            DONE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  carry_r <= cin;
                  idx     <= '0;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_seq_ctrl
//
// Purpose:
//    Self-checking bench for adder_seq_ctrl with WIDTH=16. The external 4-bit
//    adder is modelled behaviourally. Expected results are pushed to a
//    scoreboard queue when an operation is started. They are popped and
//    compared when done pulses.
//
// Ports: none (top-level bench).
// Configuration: honours ADDER_SEQ_OVF_EN to connect and check ovf.
// ---------------------------------------------------------------------------
module tb_adder_seq_ctrl;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic             slice_cin;
   logic [3:0]       slice_s;
   logic             slice_cout;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
`ifdef ADDER_SEQ_OVF_EN
   logic             ovf;
`endif

   typedef struct packed {
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   failures;
   int   done_count;
   int   cyc;

   adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .cin        (cin),
      .slice_a    (slice_a),
      .slice_b    (slice_b),
      .slice_cin  (slice_cin),
      .slice_s    (slice_s),
      .slice_cout (slice_cout),
      .busy       (busy),
      .done       (done),
      .s          (s),
      .cout       (cout)
`ifdef ADDER_SEQ_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   // Behavioural external 4-bit adder
   assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_cin};

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter for measuring pulse spacing
   always @(posedge clk) cyc++;

   // Count every done pulse so the tests can detect extra or missing pulses
   always @(negedge clk) if (done) done_count++;

   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
      exp_t        e;
      logic [16:0] t;
      t      = {1'b0, x} + {1'b0, y} + {16'd0, c};
      e.s    = t[15:0];
      e.cout = t[16];
      e.ovf  = (x[15] == y[15]) && (t[15] != x[15]);
      return e;
   endfunction

   // Pulse start for one cycle. With push=1 the expected result is queued.
   task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                                input logic c, input bit push);
      start = 1'b1;
      a     = x;
      b     = y;
      cin   = c;
      if (push) sb.push_back(model(x, y, c));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait up to budget cycles for done. On done, pop and compare the
   // scoreboard entry.
   task automatic wait_done(input int budget, output bit got);
      exp_t e;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("[TB] FAIL done_timeout: done=%b after %0d cycles, required 1", done, budget);
      end else if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL sb_unexpected_done: got done with empty scoreboard, required none");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({s, cout} !== {e.s, e.cout}) begin
            failures++;
            $display("[TB] FAIL sb_result: s=%h cout=%b, required s=%h cout=%b", s, cout, e.s, e.cout);
         end
`ifdef ADDER_SEQ_OVF_EN
         checks++;
         if (ovf !== e.ovf) begin
            failures++;
            $display("[TB] FAIL sb_ovf: ovf=%b, required %b", ovf, e.ovf);
         end
`endif
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({busy, done, cout, slice_a, slice_b, slice_cin, s} !== '0) begin
         failures++;
         $display("[TB] FAIL %s: busy=%b done=%b cout=%b sa=%h sb=%h sc=%b s=%h, required all 0",
                  name, busy, done, cout, slice_a, slice_b, slice_cin, s);
      end
`ifdef ADDER_SEQ_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s_ovf: ovf=%b, required 0", name, ovf);
      end
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      #2;
      check_all_zero("reset_t0");
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_clocked");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // 00FF + 0001: busy for 4 cycles, nibbles presented LSB first, done on the 5th
   task automatic test_basic();
      logic [15:0] av;
      bit          got;
      av = 16'h00FF;
      applyStimulus(av, 16'h0001, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_busy%0d: busy=%b done=%b, required busy=1 done=0", i, busy, done);
         end
         checks++;
         if (slice_a !== av[4*i +: 4]) begin
            failures++;
            $display("[TB] FAIL basic_slice_a%0d: slice_a=%h, required %h", i, slice_a, av[4*i +: 4]);
         end
      end
      wait_done(1, got);
      checks++;
      if (busy !== 1'b0 || s !== 16'h0100 || cout !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_done: busy=%b s=%h cout=%b, required busy=0 s=0100 cout=0", busy, s, cout);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {slice_a, slice_b, slice_cin} !== 9'd0 || s !== 16'h0100) begin
         failures++;
         $display("[TB] FAIL basic_idle_hold: busy=%b done=%b slices=%h s=%h, required 0 0 0 0100",
                  busy, done, {slice_a, slice_b, slice_cin}, s);
      end
   endtask

   task automatic test_carry_ripple();
      bit got;
      applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      wait_done(8, got);
      checks++;
      if (s !== 16'h0000 || cout !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ripple: s=%h cout=%b, required s=0000 cout=1", s, cout);
      end
      @(negedge clk);
   endtask

   // start with other operands during RUN cycle 2 is ignored
   task automatic test_start_ignored();
      int d0;
      bit got;
      d0 = done_count;
      applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 16'hFFFF;
      b     = 16'hFFFF;
      cin   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignore_busy%0d: busy=%b done=%b, required busy=1 done=0", i, busy, done);
         end
      end
      wait_done(1, got);
      checks++;
      if (s !== 16'h2345 || cout !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ignore_result: s=%h cout=%b, required s=2345 cout=0", s, cout);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (done_count - d0 !== 1 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ignore_one_done: pulses=%0d busy=%b, required pulses=1 busy=0",
                  done_count - d0, busy);
      end
   endtask

   // start held through DONE: second op starts without an IDLE cycle
   task automatic test_back_to_back();
      int c1;
      int c2;
      bit got;
      start = 1'b1;
      a     = 16'h0F0F;
      b     = 16'h00F1;
      cin   = 1'b0;
      sb.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
      @(posedge clk);
      #1;
      a   = 16'hABCD;
      b   = 16'h1357;
      cin = 1'b1;
      sb.push_back(model(16'hABCD, 16'h1357, 1'b1));
      wait_done(8, got);
      c1 = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_no_idle: busy=%b, required 1", busy);
      end
      wait_done(8, got);
      c2 = cyc;
      checks++;
      if (c2 - c1 !== 5) begin
         failures++;
         $display("[TB] FAIL b2b_spacing: spacing=%0d cycles, required 5", c2 - c1);
      end
      @(negedge clk);
   endtask

   // async reset in RUN cycle 3 aborts and clears everything immediately
   task automatic test_reset_mid_run();
      int d0;
      bit got;
      d0 = done_count;
      applyStimulus(16'h5555, 16'h2222, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if (done_count !== d0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrun_no_done: pulses=%0d busy=%b, required pulses=0 busy=0",
                  done_count - d0, busy);
      end
      applyStimulus(16'h0003, 16'h0004, 1'b0, 1'b1);
      wait_done(8, got);
      checks++;
      if (s !== 16'h0007 || cout !== 1'b0) begin
         failures++;
         $display("[TB] FAIL after_reset: s=%h cout=%b, required s=0007 cout=0", s, cout);
      end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      bit got;
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      wait_done(8, got);
      checks++;
      if (s !== 16'h8000 || cout !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ovf_pos: s=%h cout=%b, required s=8000 cout=0", s, cout);
      end
`ifdef ADDER_SEQ_OVF_EN
      checks++;
      if (ovf !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ovf_pos_flag: ovf=%b, required 1", ovf);
      end
`endif
      @(negedge clk);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1);
      wait_done(8, got);
      checks++;
      if (s !== 16'h0000 || cout !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ovf_wrap: s=%h cout=%b, required s=0000 cout=1", s, cout);
      end
`ifdef ADDER_SEQ_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ovf_wrap_flag: ovf=%b, required 0", ovf);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] r;
      bit          got;
      for (int i = 0; i < 10; i++) begin
         r = $urandom;
         applyStimulus(r[15:0], r[31:16], r[0] ^ r[17], 1'b1);
         wait_done(8, got);
      end
      @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      done_count = 0;
      cyc        = 0;
      test_reset();
      test_basic();
      test_carry_ripple();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      test_overflow();
      test_random();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL sb_leftover: %0d entries pending, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
